// File: rtl/reg_writeback_queue_pkg.sv
// Shared widths and queue entry type for the register writeback queue.
package reg_writeback_queue_pkg;
  localparam int WB_REG_W  = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_REG_W-1:0]  dst;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// Circular buffer: two ordered writes and one auto-dequeue per cycle, plus youngest-match search.
module wbq_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      wrEn0,
  input  wb_entry_t                 wrEntry0,
  input  logic                      wrEn1,
  input  wb_entry_t                 wrEntry1,
  output logic                      deq,
  output wb_entry_t                 headEntry,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [WB_REG_W-1:0]       lookupReg,
  output logic                      lookupHit,
  output logic [WB_DATA_W-1:0]      lookupData
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr, wrIdx1;

  // The second write lands right after the first, or at wrPtr when only it is valid.
  assign wrIdx1    = wrPtr + PW'(wrEn0);
  assign deq       = (count != '0);
  assign headEntry = mem[rdPtr];

  always_ff @(posedge CLK) begin
    if (wrEn0) mem[wrPtr]  <= wrEntry0;
    if (wrEn1) mem[wrIdx1] <= wrEntry1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PW'(wrEn0) + PW'(wrEn1);
      rdPtr <= rdPtr + PW'(deq);
      count <= count + (PW+1)'(wrEn0) + (PW+1)'(wrEn1) - (PW+1)'(deq);
    end
  end

  // Walk oldest to youngest so the last match standing is the youngest.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < count && lookupReg != '0 &&
          mem[rdPtr + PW'(i)].dst == lookupReg) begin
        lookupHit  = 1'b1;
        lookupData = mem[rdPtr + PW'(i)].data;
      end
    end
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue top: orders MEM/ALU results, filters $0, stalls producers, drives the retire/bypass stage.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int    DEPTH = 4,
  parameter string NAME  = "WBQ"
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 MemValid,
  input  logic [WB_REG_W-1:0]  MemReg,
  input  logic [WB_DATA_W-1:0] MemData,
  input  logic                 AluValid,
  input  logic [WB_REG_W-1:0]  AluReg,
  input  logic [WB_DATA_W-1:0] AluData,
  output logic                 Stall,
  output logic                 RegWrite,
  output logic [WB_REG_W-1:0]  WriteRegister,
  output logic [WB_DATA_W-1:0] WriteData,
  output logic [WB_REG_W-1:0]  WriteRegister1stPri,
  output logic [WB_DATA_W-1:0] WriteData1stPri,
  output logic                 Valid1stPri,
  input  logic [WB_REG_W-1:0]  LookupReg,
  output logic                 LookupHit,
  output logic [WB_DATA_W-1:0] LookupData
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0] count;
  logic        memEn, aluEn, deq;
  wb_entry_t   headEntry;

  // Stall only looks at registered occupancy, so producers never see a comb path from their own valids.
  assign Stall = count > (PW+1)'(DEPTH - 2);
  assign memEn = MemValid && !Stall && (MemReg != '0);
  assign aluEn = AluValid && !Stall && (AluReg != '0);

  wbq_fifo #(.DEPTH(DEPTH)) uFifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .wrEn0     (memEn),
    .wrEntry0  ('{dst: MemReg, data: MemData}),
    .wrEn1     (aluEn),
    .wrEntry1  ('{dst: AluReg, data: AluData}),
    .deq       (deq),
    .headEntry (headEntry),
    .count     (count),
    .lookupReg (LookupReg),
    .lookupHit (LookupHit),
    .lookupData(LookupData)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite      <= deq;
      WriteRegister <= deq ? headEntry.dst  : '0;
      WriteData     <= deq ? headEntry.data : '0;
    end
  end

  assign WriteRegister1stPri = WriteRegister;
  assign WriteData1stPri     = WriteData;
  assign Valid1stPri         = RegWrite;

  always_ff @(posedge CLK) begin
    if (!RESET) assert (count <= (PW+1)'(DEPTH)) else $error("%s: occupancy overflow", NAME);
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench: queue-based reference model predicts retires; a monitor checks every cycle's retire stage.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic        MemValid = 1'b0, AluValid = 1'b0;
  logic [4:0]  MemReg = '0, AluReg = '0, LookupReg = '0;
  logic [31:0] MemData = '0, AluData = '0;
  logic        Stall, RegWrite, Valid1stPri, LookupHit;
  logic [4:0]  WriteRegister, WriteRegister1stPri;
  logic [31:0] WriteData, WriteData1stPri, LookupData;

  reg_writeback_queue #(.DEPTH(DEPTH), .NAME("WBQ")) dut (
    .CLK(CLK), .RESET(RESET),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
    .Stall(Stall), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .WriteRegister1stPri(WriteRegister1stPri), .WriteData1stPri(WriteData1stPri),
    .Valid1stPri(Valid1stPri), .LookupReg(LookupReg), .LookupHit(LookupHit), .LookupData(LookupData)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t mq[$];    // reference queue contents, oldest first
  ent_t expQ[$];  // retires predicted for the next retire stage
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: check stall/lookup against the model, present inputs, then advance the model at the edge.
  task automatic cyc(input bit rst, input bit mv, input logic [4:0] mr, input logic [31:0] md,
                     input bit av, input logic [4:0] ar, input logic [31:0] ad, input logic [4:0] lr);
    bit stallM, hitM;
    logic [31:0] dataM;
    @(negedge CLK);
    stallM = (DEPTH - mq.size()) < 2;
    RESET = rst; MemValid = mv; MemReg = mr; MemData = md;
    AluValid = av; AluReg = ar; AluData = ad; LookupReg = lr;
    hitM = 1'b0; dataM = '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (!hitM && lr != 0 && mq[i].r == lr) begin hitM = 1'b1; dataM = mq[i].d; end
    #1;
    chk("stall", Stall, stallM);
    chk("lookupHit", LookupHit, hitM);
    chk("lookupData", LookupData, dataM);
    @(posedge CLK);
    if (rst) begin
      mq.delete(); expQ.delete();
    end else begin
      if (mq.size() > 0) expQ.push_back(mq.pop_front());
      if (!stallM) begin
        if (mv && mr != 0) mq.push_back('{mr, md});
        if (av && ar != 0) mq.push_back('{ar, ad});
      end
    end
  endtask

  task automatic idle(input int n, input logic [4:0] lr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, lr);
  endtask

  // Monitor: every retire-stage cycle is compared against the scoreboard head.
  initial begin
    ent_t e;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      #2;
      if (RegWrite) begin
        if (expQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpectedWrite actual=r%0d/%h expected=none at %0t", WriteRegister, WriteData, $time);
        end else begin
          e = expQ.pop_front();
          chk("wrReg", WriteRegister, e.r);
          chk("wrData", WriteData, e.d);
          chk("bypReg", WriteRegister1stPri, e.r);
          chk("bypData", WriteData1stPri, e.d);
          chk("bypValid", Valid1stPri, 1);
        end
      end else begin
        chk("missedWrite", expQ.size(), 0);
        expQ.delete();
        chk("idleReg", WriteRegister, 0);
        chk("idleData", WriteData, 0);
        chk("idleBypReg", WriteRegister1stPri, 0);
        chk("idleBypValid", Valid1stPri, 0);
      end
    end
  end

  initial begin
    bit ok;
    int tries;
    logic [4:0] r1, r2;
    @(posedge CLK);
    // Reset held two cycles with producers active.
    cyc(1, 1, 7, 32'h1, 1, 9, 32'h2, 7);
    cyc(1, 1, 7, 32'h1, 1, 9, 32'h2, 7);
    idle(2, 7);
    // Single ALU write on empty queue.
    cyc(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5);
    idle(2, 5);
    // Same-cycle MEM/ALU to r3; lookup must show the ALU value.
    cyc(0, 1, 3, 32'h11, 1, 3, 32'h22, 3);
    idle(3, 3);
    // Fill with dual writes, holding each pair until accepted.
    for (int k = 0; k < 4; k++) begin
      r1 = 5'(2 * k + 10); r2 = 5'(2 * k + 11);
      tries = 0; ok = 1'b0;
      while (!ok && tries < 8) begin
        ok = (DEPTH - mq.size()) >= 2;
        cyc(0, 1, r1, 32'hA000 + 32'(k), 1, r2, 32'hB000 + 32'(k), r2);
        tries++;
      end
      if (!ok) begin total++; bad++; $display("FAIL fillTimeout actual=stalled expected=accepted"); end
    end
    idle(5, 11);
    // Writes to $0 are dropped.
    cyc(0, 1, 0, 32'h55, 1, 0, 32'h66, 0);
    idle(2, 0);
    // Reset with three entries queued, then ten writes across the pointer wrap.
    cyc(0, 1, 4, 32'h44, 1, 6, 32'h66, 4);
    cyc(0, 1, 8, 32'h88, 1, 4, 32'h99, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, 4);
    for (int k = 0; k < 10; k++)
      cyc(0, k[0], 5'(k + 1), 32'hC00 + 32'(k), !k[0], 5'(k + 17), 32'hD00 + 32'(k), 5'(k + 1));
    idle(4, 1);
    // Randomized traffic with occasional reset.
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 59) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom), 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
    idle(6, 0);
    @(negedge CLK);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
